// File: rtl/aes_sbox_sched_if.sv
// Bundle of job, ISE-lookup and S-box signals around the S-box scheduler.
// Latency: none, wiring only.
// Backpressure: ISE side is req/gnt; the job side has no backpressure.
interface aes_sbox_sched_if #(
    parameter int NBYTES = 16
);
    logic                  job_start;
    logic [8*NBYTES-1:0]   job_data;
    logic                  job_busy;
    logic                  job_done;
    logic [8*NBYTES-1:0]   job_result;
    logic                  isx_req;
    logic [7:0]            isx_a;
    logic                  isx_gnt;
    logic                  isx_valid;
    logic [7:0]            isx_result;
    logic [7:0]            sb_a;
    logic [7:0]            sb_result;

    modport slave (
        input  job_start, job_data, isx_req, isx_a, sb_result,
        output job_busy, job_done, job_result, isx_gnt, isx_valid, isx_result, sb_a
    );

    modport master (
        output job_start, job_data, isx_req, isx_a, sb_result,
        input  job_busy, job_done, job_result, isx_gnt, isx_valid, isx_result, sb_a
    );
endinterface

// File: rtl/aes_sbox_sched.sv
// Time-shares one combinational AES S-box between ISE lookups (priority) and a bulk SubBytes job.
// Latency: ISE result 1 cycle after grant; job NBYTES+1 cycles start-to-done, +1 per ISE grant in RUN.
// Backpressure: ISE held off only when the job has been starved STARVE_MAX times in a row.
module aes_sbox_sched #(
    parameter int NBYTES     = 16,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    aes_sbox_sched_if.slave  bus
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [IW-1:0]             idx;
    logic [SW-1:0]             starve_cnt;
    logic [NBYTES-1:0][7:0]    job_q;
    logic [NBYTES-1:0][7:0]    res_q;
    logic                      gnt;
    logic                      job_slot;
    logic                      isx_valid_q;
    logic [7:0]                isx_result_q;

    // The ISE requester wins unless the running job has already been passed over STARVE_MAX times.
    always_comb begin
        gnt      = bus.isx_req && !(state == RUN && starve_cnt == SMAX);
        job_slot = (state == RUN) && !gnt;
    end

    // Steer the shared S-box input to whoever owns this cycle's slot.
    always_comb begin
        bus.sb_a = 8'h00;
        if (gnt)
            bus.sb_a = bus.isx_a;
        else if (job_slot)
            bus.sb_a = job_q[idx];
    end

    // Job sequencing: IDLE waits for a start, RUN walks the bytes, DONE pulses for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.job_start) state_nxt = RUN;
            RUN:  if (job_slot && idx == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Job datapath: latch input state on start, write one substituted byte per owned slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            job_q <= '0;
            res_q <= '0;
        end else if (state == IDLE && bus.job_start) begin
            idx   <= '0;
            job_q <= bus.job_data;
            res_q <= '0;
        end else if (job_slot) begin
            res_q[idx] <= bus.sb_result;
            if (idx != LAST)
                idx <= idx + 1'b1;
        end
    end

    // Count consecutive ISE wins against a running job; any job slot or leaving RUN clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (state != RUN || job_slot)
            starve_cnt <= '0;
        else if (gnt && starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Register the ISE lookup result; valid pulses the cycle after each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isx_valid_q  <= 1'b0;
            isx_result_q <= 8'h00;
        end else begin
            isx_valid_q <= gnt;
            if (gnt)
                isx_result_q <= bus.sb_result;
        end
    end

    assign bus.isx_gnt    = gnt;
    assign bus.isx_valid  = isx_valid_q;
    assign bus.isx_result = isx_result_q;
    assign bus.job_busy   = (state != IDLE);
    assign bus.job_done   = (state == DONE);
    assign bus.job_result = res_q;
endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for the S-box scheduler, with a behavioural S-box on the shared port.
// Latency: checks job start-to-done cycle counts and 1-cycle ISE result latency.
// Backpressure: exercises ISE priority and the starvation guard with a continuous request.
module tb_aes_sbox_sched;
    localparam int NB = 16;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    typedef struct {
        logic [127:0] res;
        int           lat;
        int           start;
    } job_exp_t;

    logic [7:0] isx_q [$];
    job_exp_t   job_q [$];

    aes_sbox_sched_if #(.NBYTES(NB)) bus ();

    aes_sbox_sched #(.NBYTES(NB), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Reference AES S-box: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sbox_vec(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = sbox(d[8*i +: 8]);
        return r;
    endfunction

    always_comb bus.sb_result = sbox(bus.sb_a);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive point sits 2 time units after the falling edge, after the monitor has sampled.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic start_job(input logic [127:0] d, input logic [127:0] exp, input int lat);
        job_exp_t e;
        e.res   = exp;
        e.lat   = lat;
        e.start = cyc;
        job_q.push_back(e);
        bus.job_start = 1'b1;
        bus.job_data  = d;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > d0) break;
            tick();
        end
        chk("job_done_seen", done_cnt, d0 + 1);
    endtask

    // Scoreboard: pop expectations when the DUT presents ISE results or a finished job.
    always @(negedge clk) begin
        if (!rst && bus.isx_valid) begin
            if (isx_q.size() == 0)
                chk("isx_spurious_valid", bus.isx_valid, 1'b0);
            else
                chk("isx_result", bus.isx_result, isx_q.pop_front());
        end
        if (!rst && bus.job_done) begin
            if (job_q.size() == 0) begin
                chk("job_spurious_done", bus.job_done, 1'b0);
            end else begin
                job_exp_t e;
                e = job_q.pop_front();
                chk("job_result", bus.job_result, e.res);
                chk("job_latency", cyc - e.start, e.lat);
                chk("job_busy_in_done", bus.job_busy, 1'b1);
            end
            done_cnt++;
        end
    end

    initial begin
        logic [127:0] d;
        logic [7:0]   a;
        int           d0;
        logic         exp_gnt;

        rst           = 1'b1;
        bus.job_start = 1'b0;
        bus.job_data  = '0;
        bus.isx_req   = 1'b0;
        bus.isx_a     = 8'h00;
        tick();
        chk("rst_job_busy",   bus.job_busy,   1'b0);
        chk("rst_job_done",   bus.job_done,   1'b0);
        chk("rst_job_result", bus.job_result, 128'h0);
        chk("rst_isx_valid",  bus.isx_valid,  1'b0);
        chk("rst_isx_result", bus.isx_result, 8'h00);
        chk("rst_sb_a",       bus.sb_a,       8'h00);
        tick();
        rst = 1'b0;
        tick();

        // All-zero state, no ISE traffic.
        d0 = done_cnt;
        start_job('0, {16{8'h63}}, 17);
        tick();
        bus.job_start = 1'b0;
        repeat (3) tick();
        chk("partial_result", bus.job_result, {104'h0, 24'h636363});
        chk("busy_in_run", bus.job_busy, 1'b1);
        wait_done(d0, 40);
        tick();
        chk("busy_after_done", bus.job_busy, 1'b0);

        // Incrementing bytes 00..0F against the known AES table.
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'(i);
        d0 = done_cnt;
        start_job(d, 128'h76abd7fe2b670130c56f6bf27b777c63, 17);
        tick();
        bus.job_start = 1'b0;
        wait_done(d0, 40);
        tick();

        // Single ISE lookups in IDLE.
        bus.isx_req = 1'b1;
        bus.isx_a   = 8'h53;
        #1 chk("idle_gnt_53", bus.isx_gnt, 1'b1);
        isx_q.push_back(8'hED);
        tick();
        bus.isx_a = 8'hFF;
        #1 chk("idle_gnt_ff", bus.isx_gnt, 1'b1);
        isx_q.push_back(8'h16);
        tick();
        bus.isx_req = 1'b0;
        tick();
        chk("isx_valid_drop", bus.isx_valid, 1'b0);
        chk("isx_result_held", bus.isx_result, 8'h16);

        // Three isolated ISE requests during a job.
        d0 = done_cnt;
        start_job(d, 128'h76abd7fe2b670130c56f6bf27b777c63, 20);
        tick();
        bus.job_start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            repeat (3) tick();
            a = 8'($urandom_range(0, 255));
            bus.isx_req = 1'b1;
            bus.isx_a   = a;
            #1 chk("run_isolated_gnt", bus.isx_gnt, 1'b1);
            isx_q.push_back(sbox(a));
            tick();
            bus.isx_req = 1'b0;
        end
        wait_done(d0, 60);
        tick();

        // Continuous ISE request through a whole job: starvation guard yields every fifth slot.
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        a  = 8'h10;
        start_job(d, sbox_vec(d), 81);
        bus.isx_req = 1'b1;
        bus.isx_a   = a;
        #1 chk("start_with_ise_gnt", bus.isx_gnt, 1'b1);
        isx_q.push_back(sbox(a));
        a = a + 8'h1;
        tick();
        bus.job_start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            bus.isx_a = a;
            exp_gnt = ((k % 5) != 4);
            #1 chk("starve_gnt_pattern", bus.isx_gnt, exp_gnt);
            if (exp_gnt) begin
                isx_q.push_back(sbox(a));
                a = a + 8'h1;
            end
            tick();
        end
        bus.isx_req = 1'b0;
        chk("starve_done_count", done_cnt, d0 + 1);
        tick();
        chk("starve_busy_after", bus.job_busy, 1'b0);

        // Reset in the middle of a job aborts it without a done pulse.
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        start_job(d, sbox_vec(d), 17);
        tick();
        bus.job_start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        void'(job_q.pop_back());
        chk("abort_job_busy",   bus.job_busy,   1'b0);
        chk("abort_job_done",   bus.job_done,   1'b0);
        chk("abort_job_result", bus.job_result, 128'h0);
        chk("abort_isx_valid",  bus.isx_valid,  1'b0);
        chk("abort_isx_result", bus.isx_result, 8'h00);
        chk("abort_sb_a",       bus.sb_a,       8'h00);
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("abort_no_done", done_cnt, d0);

        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
        d0 = done_cnt;
        start_job(d, sbox_vec(d), 17);
        tick();
        bus.job_start = 1'b0;
        wait_done(d0, 40);
        tick();

        chk("isx_queue_drained", isx_q.size(), 0);
        chk("job_queue_drained", job_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_sbox_sched.md
Name: aes_sbox_sched

Overview:
Scheduler that time-shares one combinational AES S-box (an external asb_ise instance) between two requesters. The first is single-byte core ISE lookups from the HOKSTER ALU. The second is a byte-serial bulk SubBytes job over an NBYTES-wide state used by the LWC block-cipher path. ISE lookups have priority. A starvation guard guarantees the bulk job forward progress.

Parameters:
NBYTES, 16, bytes per bulk job (legal range 1..16).
STARVE_MAX, 4, max consecutive ISE grants while a job is running before the job is forced one slot.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
job_start  in  1  start bulk job; sampled only in IDLE
job_data  in  8*NBYTES  input state; byte i = bits [8i+7:8i]
job_busy  out  1  high in RUN and DONE
job_done  out  1  one-cycle pulse when job_result is complete
job_result  out  8*NBYTES  substituted state; held until next accepted job_start
isx_req  in  1  ISE lookup request; held until isx_gnt
isx_a  in  8  ISE lookup byte; stable while isx_req is high
isx_gnt  out  1  combinational grant this cycle
isx_valid  out  1  registered; high the cycle after a grant
isx_result  out  8  registered S-box result; held until next grant
sb_a  out  8  to the S-box input
sb_result  in  8  from the S-box output, combinational

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, idx=0, starve_cnt=0, job_busy=0, job_done=0, job_result=0, isx_valid=0, isx_result=0. Reset mid-job aborts the job; no job_done is issued.
- States:
  - IDLE: on job_start=1, latch job_data, clear idx and job_result, go to RUN.
  - RUN: when the job owns the slot, job_result byte[idx] <= sb_result. If idx==NBYTES-1, go to DONE; else idx++.
  - DONE: job_done=1 for exactly this cycle, then go to IDLE.
- job_start is ignored in RUN and DONE. A job_start in IDLE coincident with an ISE request is accepted as well, since the start itself does not use the S-box.
- Slot arbitration, combinational each cycle:
  - isx_gnt = isx_req AND NOT (state==RUN AND starve_cnt==STARVE_MAX).
  - The job owns the slot when state==RUN AND NOT isx_gnt.
- sb_a mux:
  - isx_a if isx_gnt;
  - else latched job byte[idx] if the job owns the slot;
  - else 8'h00.
- ISE result path: on a grant, isx_result <= sb_result and isx_valid <= 1 at the next edge; otherwise isx_valid <= 0. Back-to-back grants give back-to-back isx_valid pulses.
- starve_cnt:
  - increments on each isx_gnt while in RUN;
  - clears when the job owns a slot;
  - clears in any state other than RUN;
  - saturates at STARVE_MAX.
- Latency, with no ISE traffic: job_start accepted at edge E0; bytes are written at edges E1..E_NBYTES; job_done is high in the cycle after E_NBYTES. Total start-to-done is NBYTES+1 cycles.
- Each ISE grant during RUN delays job completion by one cycle. Worst-case job latency is NBYTES*(STARVE_MAX+1)+1 cycles.
- ISE latency: 1 cycle from grant to isx_valid.
- job_result bytes not yet processed read 0 during RUN. The full result is stable from the job_done cycle until the next accepted job_start.

Test Plan:
- Reset, then job_data=all 8'h00, no ISE traffic -> job_done 17 cycles after start; job_result = all bytes 8'h63; job_busy low the cycle after job_done.
- job_data bytes 0..15 = 8'h00..8'h0F -> job_result bytes 0..15 = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76.
- In IDLE, isx_req=1, isx_a=8'h53 -> isx_gnt=1 same cycle; next cycle isx_valid=1, isx_result=8'hED. Then isx_a=8'hFF -> 8'h16.
- Job with 3 isolated ISE requests mid-run -> each granted immediately; job_done at cycle 20; job_result identical to the no-traffic run.
- isx_req held high throughout a 16-byte job -> isx_gnt pattern is 4 high, 1 low, repeated; job completes in 81 cycles; ISE results correct for each grant.
- Assert rst at byte 7 of a job -> all outputs 0 immediately; no job_done. A new job after reset completes normally in 17 cycles.
